// File: rtl/addroundkey_stage.sv
// AES AddRoundKey pipeline stage: XORs the column-mixed state with the round key and tags each beat
// with its round index. Define ADDROUNDKEY_SKID_EN for a 2-entry skid buffer with registered in_ready.
module addroundkey_stage #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   out_round,
    output logic         out_last
);

    localparam logic [3:0] NR_L = 4'(NR);

    logic         accept;
    logic         transfer;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic [3:0]   tag;
    logic         tag_last;
    logic [127:0] xored;

    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;
    // restart overrides the counter for a beat accepted in the same cycle
    assign tag      = restart ? 4'd1 : cnt_q;
    assign tag_last = (tag == NR_L);
    assign xored    = in_data ^ in_key;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = tag_last ? 4'd1 : tag + 4'd1;
        end else if (restart) begin
            cnt_d = 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd1;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef ADDROUNDKEY_SKID_EN
    logic         ready_q;
    logic         skid_valid_q;
    logic [127:0] skid_data_q;
    logic [3:0]   skid_round_q;
    logic         skid_last_q;

    assign in_ready = ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q      <= 1'b1;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_round_q <= '0;
            skid_last_q  <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_round    <= '0;
            out_last     <= 1'b0;
        end else if (!out_valid || transfer) begin
            // Output slot frees up: skid entry has priority over the incoming beat
            if (skid_valid_q) begin
                out_valid    <= 1'b1;
                out_data     <= skid_data_q;
                out_round    <= skid_round_q;
                out_last     <= skid_last_q;
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= xored;
                out_round <= tag;
                out_last  <= tag_last;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= xored;
            skid_round_q <= tag;
            skid_last_q  <= tag_last;
            ready_q      <= 1'b0;
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= xored;
            out_round <= tag;
            out_last  <= tag_last;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_addroundkey_stage.sv
// Self-checking bench for addroundkey_stage; expectations come from a round-counter/XOR model
// and a scoreboard queue. Builds with or without ADDROUNDKEY_SKID_EN.
module tb_addroundkey_stage;

    localparam int NR = 10;

    logic         clk;
    logic         rst;
    logic         restart;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic         out_last;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } beat_t;

    int checks = 0;
    int passed = 0;

    addroundkey_stage #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_round (out_round),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Leaves the bench 1 time unit after a rising edge with the DUT freshly reset.
    task automatic do_reset();
        rst = 1'b1;
        restart = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_key = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        restart = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_key = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_held: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_round !== 4'd0 || out_last !== 1'b0)
            $display("FAIL reset_outputs: v=%b d=%h r=%0d l=%b, want all zero",
                     out_valid, out_data, out_round, out_last);
        else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b, want 1", in_ready);
        else passed++;
    endtask

    task automatic test_fips();
        logic [127:0] want;
        want = 128'ha49c7ff2689f352b6b5bea43026a5049;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 128'h046681e5e0cb199a48f8d37a2806264c;
        in_key = 128'ha0fafe1788542cb123a339392a6c7605;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== want || out_round !== 4'd1 || out_last !== 1'b0)
            $display("FAIL fips_vector: v=%b d=%h r=%0d l=%b, want 1 %h 1 0",
                     out_valid, out_data, out_round, out_last, want);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL fips_drain: out_valid=%b, want 0", out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] want;
        int round;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data = rand128();
            in_key = rand128();
            want = in_data ^ in_key;
            round = (i % NR) + 1;
            #1;
            checks++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", i, in_ready);
            else passed++;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== want || out_round !== 4'(round)
                || out_last !== (round == NR))
                $display("FAIL b2b_beat[%0d]: v=%b d=%h r=%0d l=%b, want 1 %h %0d %b",
                         i, out_valid, out_data, out_round, out_last, want, round, round == NR);
            else passed++;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [127:0] a;
        logic [127:0] b;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = rand128();
        in_key = rand128();
        a = in_data ^ in_key;
        @(posedge clk);
        #1;
        in_data = rand128();
        in_key = rand128();
        b = in_data ^ in_key;
        checks++;
        if (out_valid !== 1'b1 || out_data !== a || out_round !== 4'd1)
            $display("FAIL stall_a: v=%b d=%h r=%0d, want 1 %h 1", out_valid, out_data, out_round, a);
        else passed++;
`ifdef ADDROUNDKEY_SKID_EN
        checks++;
        if (in_ready !== 1'b1) $display("FAIL stall_skid_free: in_ready=%b, want 1", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        in_data = rand128();
        in_key = rand128();
        checks++;
        if (in_ready !== 1'b0 || out_data !== a || out_round !== 4'd1)
            $display("FAIL stall_full: rdy=%b d=%h r=%0d, want 0 %h 1", in_ready, out_data, out_round, a);
        else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== a)
            $display("FAIL stall_refuse: rdy=%b v=%b d=%h, want 0 1 %h", in_ready, out_valid, out_data, a);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== b || out_round !== 4'd2 || in_ready !== 1'b1)
            $display("FAIL stall_b: v=%b d=%h r=%0d rdy=%b, want 1 %h 2 1",
                     out_valid, out_data, out_round, in_ready, b);
        else passed++;
`else
        checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_ready_low: in_ready=%b, want 0", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== a || out_round !== 4'd1 || in_ready !== 1'b0)
            $display("FAIL stall_hold: d=%h r=%0d rdy=%b, want %h 1 0", out_data, out_round, in_ready, a);
        else passed++;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL stall_release: in_ready=%b, want 1", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== b || out_round !== 4'd2)
            $display("FAIL stall_b: v=%b d=%h r=%0d, want 1 %h 2", out_valid, out_data, out_round, b);
        else passed++;
`endif
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL stall_drain: out_valid=%b, want 0", out_valid);
        else passed++;
    endtask

    task automatic test_restart();
        logic [127:0] want;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = rand128();
            in_key = rand128();
            @(posedge clk);
            #1;
        end
        restart = 1'b1;
        in_data = rand128();
        in_key = rand128();
        want = in_data ^ in_key;
        #1;
        checks++;
        if (out_round !== 4'd3) $display("FAIL restart_held: out_round=%0d, want 3", out_round);
        else passed++;
        @(posedge clk);
        #1;
        restart = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== want || out_round !== 4'd1)
            $display("FAIL restart_tag1: v=%b d=%h r=%0d, want 1 %h 1", out_valid, out_data, out_round, want);
        else passed++;
        in_data = rand128();
        in_key = rand128();
        @(posedge clk);
        #1;
        checks++;
        if (out_round !== 4'd2) $display("FAIL restart_tag2: out_round=%0d, want 2", out_round);
        else passed++;
        // restart on an idle cycle still reloads the counter
        in_valid = 1'b0;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_round !== 4'd1)
            $display("FAIL restart_idle: v=%b r=%0d, want 1 1", out_valid, out_round);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = rand128();
            in_key = rand128();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) $display("FAIL areset_pre: out_valid=%b, want 1", out_valid);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_round !== 4'd0 || out_last !== 1'b0
            || in_ready !== 1'b1)
            $display("FAIL areset_async: v=%b d=%h r=%0d l=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, out_data, out_round, out_last, in_ready);
        else passed++;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL areset_empty: out_valid=%b, want 0", out_valid);
        else passed++;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = rand128();
        in_key = rand128();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_round !== 4'd1)
            $display("FAIL areset_tag1: v=%b r=%0d, want 1 1", out_valid, out_round);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        beat_t q[$];
        beat_t exp;
        int mcnt;
        int sent;
        int cycles;
        int round;
        int errs;
        logic pending;
        do_reset();
        mcnt = 1;
        sent = 0;
        cycles = 0;
        errs = 0;
        pending = 1'b0;
        while ((sent < 1000 || q.size() != 0) && cycles < 20000) begin
            if (!pending && sent < 1000 && ($urandom % 4) != 0) begin
                pending = 1'b1;
                in_data = rand128();
                in_key = rand128();
            end
            in_valid = pending;
            restart = (($urandom % 32) == 0);
            out_ready = (($urandom % 3) != 0);
            #1;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL rand_extra: out_valid with empty scoreboard, d=%h", out_data);
                    errs++;
                end else begin
                    exp = q[0];
                    if (out_data !== exp.data || out_round !== exp.round || out_last !== exp.last) begin
                        $display("FAIL rand_beat: d=%h r=%0d l=%b, want %h %0d %b",
                                 out_data, out_round, out_last, exp.data, exp.round, exp.last);
                        errs++;
                    end else passed++;
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                round = restart ? 1 : mcnt;
                mcnt = (round % NR) + 1;
                exp.data = in_data ^ in_key;
                exp.round = 4'(round);
                exp.last = (round == NR);
                q.push_back(exp);
                sent++;
                pending = 1'b0;
            end else if (restart) begin
                mcnt = 1;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        restart = 1'b0;
        checks++;
        if (sent != 1000 || q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL rand_complete: sent=%0d left=%0d v=%b, want 1000 0 0", sent, q.size(), out_valid);
        else passed++;
        checks++;
        if (errs != 0) $display("FAIL rand_errors: %0d beat errors, want 0", errs);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_back_to_back();
        test_stall();
        test_restart();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
